// File: rtl/arb_pkg.sv
// arb_pkg: shared FSM state encoding (state_e) and arbitration mode constants (MODE_FIXED, MODE_RR) for req_arbiter
package arb_pkg;
  typedef enum logic {IDLE, GRANT} state_e;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR = 1'b1;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational winner search; in req, ptr (rr start), mode; out win (index), valid (any request)
module arb_pick import arb_pkg::*; #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         mode,
  output logic [W-1:0] win,
  output logic         valid
);
  logic [W-1:0] hi, lo_m, lo_u;
  logic         fm;
  always_comb begin
    hi = '0;
    lo_m = '0;
    lo_u = '0;
    fm = 1'b0;
    for (int i = 0; i < N; i++) if (req[i]) hi = W'(i);
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) lo_u = W'(i);
      if (req[i] && i >= int'(ptr)) begin
        lo_m = W'(i);
        fm = 1'b1;
      end
    end
    win = mode == MODE_RR ? (fm ? lo_m : lo_u) : hi;
  end
  assign valid = |req;
endmodule

// File: rtl/req_arbiter.sv
// req_arbiter: fixed/round-robin grant holder; in clk, reset (async), req, done, mode; out gnt (one-hot), owner, busy, timeout
module req_arbiter import arb_pkg::*; #(
  parameter int N = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 done,
  input  logic                 mode,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic                 timeout
);
  localparam int W = $clog2(N);
  localparam int CW = $clog2(MAX_HOLD);
  state_e          state, state_n;
  logic [W-1:0]    ptr, ptr_n, win, owner_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [N-1:0]    gnt_n;
  logic            gmode, gmode_n, busy_n, to_n, valid, lim, rel;
  arb_pick #(.N(N), .W(W)) u_pick (
    .req  (req),
    .ptr  (ptr),
    .mode (mode),
    .win  (win),
    .valid(valid)
  );
  assign lim = cnt == CW'(MAX_HOLD - 1);
  assign rel = done || !req[owner] || lim;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gnt <= '0;
      owner <= '0;
      busy <= 1'b0;
      timeout <= 1'b0;
      ptr <= '0;
      cnt <= '0;
      gmode <= MODE_FIXED;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      owner <= owner_n;
      busy <= busy_n;
      timeout <= to_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      gmode <= gmode_n;
    end
  end
  always_comb begin
    state_n = state;
    gnt_n = gnt;
    owner_n = owner;
    busy_n = busy;
    to_n = 1'b0;
    ptr_n = ptr;
    cnt_n = cnt;
    gmode_n = gmode;
    if (state == IDLE) begin
      if (valid) begin
        state_n = GRANT;
        gnt_n = N'(1) << win;
        owner_n = win;
        busy_n = 1'b1;
        cnt_n = '0;
        gmode_n = mode;
      end
    end else if (rel) begin
      state_n = IDLE;
      gnt_n = '0;
      owner_n = '0;
      busy_n = 1'b0;
      to_n = lim && !done && req[owner];
      ptr_n = gmode == MODE_RR ? (owner == W'(N - 1) ? '0 : owner + 1'b1) : ptr;
    end else begin
      cnt_n = cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_req_arbiter.sv
// tb_req_arbiter: directed and random checks of req_arbiter against a cycle-level behavioural model
module tb_req_arbiter;
  localparam int N = 4;
  localparam int MAX_HOLD = 8;
  logic         clk = 1'b0;
  logic         reset, done, mode;
  logic [N-1:0] req, gnt;
  logic [1:0]   owner;
  logic         busy, timeout;
  int checks = 0;
  int errors = 0;
  int m_own, m_len, m_ptr, m_mode;
  bit m_to;
  req_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done), .mode(mode),
    .gnt(gnt), .owner(owner), .busy(busy), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic m_reset();
    m_own = -1;
    m_len = 0;
    m_ptr = 0;
    m_mode = 0;
    m_to = 0;
  endtask
  function automatic int pick(input logic [N-1:0] r, input logic md, input int p);
    int w = -1;
    if (md == 1'b0) begin
      for (int i = 0; i < N; i++) if (r[i]) w = i;
    end else begin
      for (int k = N - 1; k >= 0; k--) if (r[(p + k) % N]) w = (p + k) % N;
    end
    return w;
  endfunction
  task automatic m_release(input bit forced);
    if (m_mode == 1) m_ptr = (m_own + 1) % N;
    m_own = -1;
    m_to = forced;
  endtask
  task automatic m_edge();
    m_to = 0;
    if (reset) m_reset();
    else if (m_own < 0) begin
      if (req != 0) begin
        m_own = pick(req, mode, m_ptr);
        m_len = 1;
        m_mode = int'(mode);
      end
    end else if (done || !req[m_own]) m_release(0);
    else if (m_len == MAX_HOLD) m_release(1);
    else m_len++;
  endtask
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask
  task automatic check(input string tag);
    chk({tag, ".gnt"}, 32'(gnt), m_own < 0 ? 32'd0 : 32'd1 << m_own);
    chk({tag, ".owner"}, 32'(owner), m_own < 0 ? 32'd0 : 32'(m_own));
    chk({tag, ".busy"}, 32'(busy), 32'(m_own >= 0));
    chk({tag, ".timeout"}, 32'(timeout), 32'(m_to));
  endtask
  task automatic step(input string tag);
    @(posedge clk);
    m_edge();
    #1;
    check(tag);
  endtask
  task automatic async_reset();
    #2 reset = 1'b1;
    m_reset();
    #1 check("async_reset");
    @(posedge clk);
    #1 check("reset_held");
    reset = 1'b0;
  endtask
  logic [N-1:0] seq [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
  initial begin
    reset = 1'b1;
    req = '0;
    done = 1'b0;
    mode = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 check("reset");
    reset = 1'b0;
    repeat (5) step("idle");
    req = 4'b1011;
    step("fix_g1");
    chk("fix_g1_gnt", 32'(gnt), 32'b1000);
    step("fix_g2");
    done = 1'b1;
    step("fix_rel");
    chk("fix_dead_gnt", 32'(gnt), 32'b0000);
    done = 1'b0;
    step("fix_regrant");
    chk("fix_regrant_gnt", 32'(gnt), 32'b1000);
    req = '0;
    step("fix_drop");
    async_reset();
    mode = 1'b1;
    req = 4'b1111;
    done = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step("rr_seq");
      chk("rr_seq_gnt", 32'(gnt), 32'(seq[i]));
    end
    done = 1'b0;
    req = '0;
    repeat (2) step("rr_idle");
    req = 4'b0100;
    for (int i = 0; i < MAX_HOLD; i++) begin
      step("hold");
      chk("hold_gnt", 32'(gnt), 32'b0100);
    end
    req = 4'b1100;
    step("forced");
    chk("forced_timeout", 32'(timeout), 32'd1);
    step("after_to");
    chk("after_to_gnt", 32'(gnt), 32'b1000);
    req = '0;
    step("clr");
    mode = 1'b0;
    req = 4'b0001;
    for (int i = 0; i < MAX_HOLD; i++) step("coin");
    done = 1'b1;
    step("coin_rel");
    chk("coin_timeout", 32'(timeout), 32'd0);
    done = 1'b0;
    req = '0;
    step("clr2");
    mode = 1'b1;
    req = 4'b0010;
    repeat (3) step("drop_hold");
    req = 4'b0000;
    step("drop_rel");
    chk("drop_timeout", 32'(timeout), 32'd0);
    req = 4'b0010;
    repeat (3) step("mid");
    chk("mid_gnt", 32'(gnt), 32'b0010);
    async_reset();
    chk("mid_reset_gnt", 32'(gnt), 32'd0);
    req = 4'b1111;
    step("post_reset");
    chk("post_reset_gnt", 32'(gnt), 32'b0001);
    for (int i = 0; i < 400; i++) begin
      req = N'($urandom);
      done = $urandom_range(0, 5) == 0;
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      step("rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/req_arbiter.md
# req_arbiter

Sequential arbiter sharing one resource among N requesters. Supports a fixed-priority mode where the highest index wins, matching the team's priority-encoder convention, and a round-robin mode. A grant is held until the owner releases, the owner drops its request, or a hold-timeout forces release. It sits between client request lines and any shared datapath that needs a one-hot select plus an owner index.

## Interface
- `N`, default 4: number of requesters; legal range is 2..16.
- `MAX_HOLD`, default 8: maximum consecutive grant cycles before a forced release; must be ≥ 2.
- `clk`  in  1  single clock; rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  N  request lines, level-sensitive.
- `done`  in  1  release strobe from the current owner; honoured only in GRANT.
- `mode`  in  1  0 = fixed priority (highest index wins), 1 = round-robin.
- `gnt`  out  N  one-hot grant; all-zero when no owner.
- `owner`  out  $clog2(N)  index of the granted requester; 0 when idle.
- `busy`  out  1  high while in GRANT.
- `timeout`  out  1  one-cycle pulse on a forced release.

## Operation
- Reset values: state=IDLE, gnt=0, owner=0, busy=0, timeout=0, rr pointer=0, hold counter=0. Applied asynchronously, including mid-grant.
- All outputs are registered.
- FSM has two states: IDLE and GRANT.
- IDLE, req==0: stay in IDLE.
- IDLE, req!=0:
  - Pick winner w.
  - Load gnt=1<<w, owner=w, hold counter=0.
  - Go to GRANT.
- Winner selection:
  - mode=0: highest set index of req.
  - mode=1: first set bit found scanning upward from the rr pointer, wrapping from N-1 to 0.
- GRANT exit conditions, evaluated each edge, in priority order:
  1. done=1 → normal release.
  2. req[owner]=0 → normal release.
  3. hold counter==MAX_HOLD-1 → forced release; timeout=1 on the next cycle.
  4. Otherwise increment the hold counter and stay in GRANT.
- On any release:
  - gnt=0, owner=0, busy=0.
  - Return to IDLE.
  - In mode=1, the rr pointer becomes (released owner+1) mod N. In mode=0, the pointer is unchanged.
- A change of `mode` during GRANT takes effect only at the next arbitration.
- Changes to non-owner req bits during GRANT are ignored.

## Timing
- Grant latency: req seen at edge k → gnt valid in the cycle after edge k.
- Release latency: done (or req drop) sampled at edge k → gnt=0 in the cycle after edge k.
- One mandatory dead cycle in IDLE between consecutive grants, even to the same requester.
- Maximum grant length is MAX_HOLD cycles.
- timeout is high only in the first IDLE cycle after a forced release.
- done and hold-limit in the same cycle count as a normal release: timeout stays 0.
- req dropping and the hold-limit in the same cycle also count as a normal release.
- done while in IDLE is ignored.
- Worst-case wait for a continuously asserted requester in mode=1 is (N-1)·(MAX_HOLD+1) cycles.

## Structure
- Package `arb_pkg`:
  - `state_e` enum {IDLE, GRANT}.
  - `MODE_FIXED`=1'b0 and `MODE_RR`=1'b1 constants.
- Sub-module `arb_pick`: combinational, takes req, pointer and mode; outputs winner index and a valid flag. Implemented as a masked priority search: a masked pass (bits ≥ pointer) and an unmasked pass.
- Top level holds the FSM, hold counter, rr pointer and output registers.

## Test plan
- Reset, then req=4'b0000 for 5 cycles → gnt=0000, owner=0, busy=0, timeout=0 throughout.
- mode=0, req=4'b1011, done pulsed on the 2nd grant cycle → gnt=1000 and owner=3 for 2 cycles, then one cycle with gnt=0, then gnt=1000 again.
- mode=1 from reset, req=4'b1111 held, done pulsed on each grant's 1st cycle → gnt sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
- mode=1, req=4'b0100 held with no done → gnt=0100 for exactly 8 cycles, then gnt=0 with timeout=1 for 1 cycle. With req then set to 4'b1100, the next grant is 1000.
- gnt=0010 mid-hold, reset asserted between edges → gnt=0, busy=0, owner=0 immediately; after deassertion with req=4'b1111 in mode=1, the first grant is 0001.
- done and hold-limit coincide on grant cycle 8 → release with timeout=0. Separately, req[owner] dropped on cycle 3 → gnt=0 on the next cycle, timeout=0.
